cfa_frame_store: RTL
====================

# cfa_frame_store

Frame-memory responder on the far side of the CFA demosaic core's memory interface. It loads one raw Bayer frame from an input stream and serves the core's combinational raw/green/red/blue reads. It captures the core's per-channel writes, then streams the finished RGB frame out. Sits between the sensor/DMA stream and the CFA core; it owns the core's `start` and consumes its `done`.

## Interface
Parameters:
- DATA_W, 12, pixel/channel width
- ADDR_W, 17, core address width
- DEPTH, 4096, pixel locations per plane (raw, green, red, blue)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- rowMax  in  11  frame rows; sampled at load_start
- colMax  in  11  frame columns; sampled at load_start
- load_start  in  1  pulse: begin a frame
- in_valid  in  1  raw pixel valid
- in_data  in  DATA_W  raw pixel, raster order
- in_ready  out  1  raw pixel accepted when in_valid&&in_ready
- start  out  1  one-cycle start pulse to core
- done  in  1  core frame complete
- readAddress  in  ADDR_W  core read address
- raw, greenRead, redRead, blueRead  out  DATA_W  combinational read data at readAddress
- writeAddress  in  ADDR_W  core write address
- writeEnable  in  3  bit0 green, bit1 red, bit2 blue
- greenWrite, redWrite, blueWrite  in  DATA_W  core write data
- out_valid  out  1  RGB pixel valid
- out_ready  in  1  downstream accept
- out_r, out_g, out_b  out  DATA_W  RGB pixel, raster order
- out_last  out  1  high with final pixel
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse after last output handshake
- error  out  1  sticky: rejected frame size; cleared by next accepted load_start or rst

## Operation
- States: IDLE, LOAD, RUN, DRAIN.
- N = rowMax*colMax, computed at full 22-bit width and latched at load_start.
- IDLE: on load_start, if N==0 or N>DEPTH, set error and stay IDLE; otherwise clear error, latch N, zero the pixel counter, go to LOAD.
- LOAD: in_ready=1. Each handshake writes in_data to raw[cnt], then cnt++. When the handshake with cnt==N-1 occurs, go to RUN.
- RUN: start=1 on the first RUN cycle only. Core writes apply: each set writeEnable bit writes its channel at writeAddress on the clock edge. When done is sampled high, go to DRAIN with cnt=0.
- DRAIN: out_valid=1. out_r/g/b come combinationally from red/green/blue[cnt]; out_last=(cnt==N-1). Each out_valid&&out_ready increments cnt. The final handshake returns the block to IDLE and pulses frame_done.
- Reads are always active in every state. Address >= DEPTH returns 0 on all four read ports.
- Writes with address >= DEPTH are dropped. writeEnable is ignored outside RUN.
- Ignored: load_start outside IDLE; done outside RUN; in_valid outside LOAD.
- Memory arrays are not reset; contents are retained across rst.

## Timing
- Reset values: in_ready, start, out_valid, out_last, frame_done, busy, error all 0. State IDLE, cnt 0.
- rst asserted mid-frame aborts immediately to IDLE. No start or frame_done pulse is issued.
- load_start at edge t: in_ready=1 from t+1.
- Last LOAD handshake at edge t: start=1 during cycle t+1 to t+2, exactly one cycle.
- Read latency is 0 cycles (combinational from readAddress). Write takes effect at the edge; the same address reads the new value in the following cycle.
- done at edge t: out_valid=1 from t+1.
- Throughput is one pixel per cycle in both LOAD and DRAIN. in_valid gaps and out_ready backpressure stall cnt; outputs hold stable while out_valid && !out_ready.
- Last DRAIN handshake at edge t: frame_done=1 for cycle t+1 and busy=0 from t+1. load_start is accepted again from t+1.

## Test plan
- 3x3 frame, raw values 1..9 streamed back-to-back. Stub core reads each address, writes g=raw, r=raw+100, b=raw+200, then pulses done. Required: single start pulse; out stream (101,1,201)…(109,9,209); out_last only on the 9th pixel; frame_done one cycle later.
- Same frame with in_valid toggling every other cycle and out_ready low 2 of every 3 cycles. Required: identical data, no duplicated or skipped pixels, outputs stable while stalled.
- rowMax=64, colMax=65 (N=4160 > 4096), then rowMax=0. Required: error=1, in_ready stays 0, busy 0. A following valid 2x2 load_start clears error.
- writeEnable=3'b111 at address 5 while in LOAD and in DRAIN. Required: green/red/blue[5] unchanged. readAddress=5000 returns 0 on all four read ports.
- rst asserted after 4 of 9 LOAD handshakes. Required: all outputs 0 next cycle, state IDLE. A subsequent full 3x3 frame completes normally.
- done and load_start asserted during LOAD. Required: both ignored; start is still issued after the 9th pixel.

Source files
------------

// File: rtl/cfa_frame_store.sv
// cfa_frame_store: frame memory sitting behind the CFA demosaic core.
// Loads one raw Bayer frame from a valid/ready stream into the raw plane.
// Serves combinational raw/green/red/blue reads to the core and captures
// its per-channel writes while it runs. Finally streams the RGB frame out
// in raster order.
//
// Ports:
//   clk, rst                        clock, async active-high reset
//   rowMax, colMax, load_start      frame geometry, sampled when a frame begins
//   in_valid, in_data, in_ready     raw pixel input stream
//   start, done                     core handshake (start pulse / completion)
//   readAddress, raw, *Read         core read port (0-cycle latency)
//   writeAddress, writeEnable, *Write  core per-channel write port
//   out_valid, out_ready, out_r/g/b, out_last  RGB output stream
//   busy, frame_done, error         status
module cfa_frame_store #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned DEPTH  = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [10:0]       rowMax,
  input  logic [10:0]       colMax,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              start,
  input  logic              done,
  input  logic [ADDR_W-1:0] readAddress,
  output logic [DATA_W-1:0] raw,
  output logic [DATA_W-1:0] greenRead,
  output logic [DATA_W-1:0] redRead,
  output logic [DATA_W-1:0] blueRead,
  input  logic [ADDR_W-1:0] writeAddress,
  input  logic [2:0]        writeEnable,
  input  logic [DATA_W-1:0] greenWrite,
  input  logic [DATA_W-1:0] redWrite,
  input  logic [DATA_W-1:0] blueWrite,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_r,
  output logic [DATA_W-1:0] out_g,
  output logic [DATA_W-1:0] out_b,
  output logic              out_last,
  output logic              busy,
  output logic              frame_done,
  output logic              error
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned N_W   = 22;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

  state_t           state_q, state_n;
  logic [IDX_W-1:0] cnt_q, cnt_n;
  logic [IDX_W-1:0] last_q, last_n;   // N-1, latched at frame start
  logic [N_W-1:0]   n_full;
  logic             n_ok;
  logic             in_hs, out_hs;
  logic             in_ready_n, start_n, out_valid_n, out_last_n;
  logic             frame_done_n, busy_n, error_n;

  logic [DATA_W-1:0] raw_mem   [DEPTH];
  logic [DATA_W-1:0] green_mem [DEPTH];
  logic [DATA_W-1:0] red_mem   [DEPTH];
  logic [DATA_W-1:0] blue_mem  [DEPTH];

  logic             rd_ok, wr_ok;
  logic [IDX_W-1:0] rd_idx, wr_idx;

  // Frame size at full product width so oversize frames cannot alias small ones
  assign n_full = N_W'(rowMax) * N_W'(colMax);
  assign n_ok   = (n_full != '0) && (n_full <= N_W'(DEPTH));

  assign in_hs  = (state_q == LOAD) && in_valid && in_ready;
  assign out_hs = (state_q == DRAIN) && out_valid && out_ready;

  assign rd_ok  = readAddress < ADDR_W'(DEPTH);
  assign wr_ok  = writeAddress < ADDR_W'(DEPTH);
  assign rd_idx = readAddress[IDX_W-1:0];
  assign wr_idx = writeAddress[IDX_W-1:0];

  // Core read port: out-of-range addresses read as zero
  assign raw       = rd_ok ? raw_mem[rd_idx]   : '0;
  assign greenRead = rd_ok ? green_mem[rd_idx] : '0;
  assign redRead   = rd_ok ? red_mem[rd_idx]   : '0;
  assign blueRead  = rd_ok ? blue_mem[rd_idx]  : '0;

  // Output pixel follows the drain counter
  assign out_r = red_mem[cnt_q];
  assign out_g = green_mem[cnt_q];
  assign out_b = blue_mem[cnt_q];

  // Memory planes: not reset, contents survive rst
  always_ff @(posedge clk) begin
    if (in_hs) begin
      raw_mem[cnt_q] <= in_data;
    end
    if ((state_q == RUN) && wr_ok) begin
      if (writeEnable[0]) green_mem[wr_idx] <= greenWrite;
      if (writeEnable[1]) red_mem[wr_idx]   <= redWrite;
      if (writeEnable[2]) blue_mem[wr_idx]  <= blueWrite;
    end
  end

  // State and status registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      last_q     <= '0;
      in_ready   <= 1'b0;
      start      <= 1'b0;
      out_valid  <= 1'b0;
      out_last   <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state_q    <= state_n;
      cnt_q      <= cnt_n;
      last_q     <= last_n;
      in_ready   <= in_ready_n;
      start      <= start_n;
      out_valid  <= out_valid_n;
      out_last   <= out_last_n;
      frame_done <= frame_done_n;
      busy       <= busy_n;
      error      <= error_n;
    end
  end

  // Next state plus next values of the registered outputs
  always_comb begin
    state_n      = state_q;
    cnt_n        = cnt_q;
    last_n       = last_q;
    in_ready_n   = 1'b0;
    start_n      = 1'b0;
    out_valid_n  = 1'b0;
    out_last_n   = 1'b0;
    frame_done_n = 1'b0;
    error_n      = error;

    unique case (state_q)
      IDLE: begin
        if (load_start) begin
          if (!n_ok) begin
            error_n = 1'b1;
          end else begin
            error_n    = 1'b0;
            last_n     = IDX_W'(n_full - N_W'(1));
            cnt_n      = '0;
            state_n    = LOAD;
            in_ready_n = 1'b1;
          end
        end
      end
      LOAD: begin
        in_ready_n = 1'b1;
        if (in_hs) begin
          if (cnt_q == last_q) begin
            state_n    = RUN;
            start_n    = 1'b1;
            in_ready_n = 1'b0;
          end else begin
            cnt_n = cnt_q + IDX_W'(1);
          end
        end
      end
      RUN: begin
        if (done) begin
          state_n     = DRAIN;
          cnt_n       = '0;
          out_valid_n = 1'b1;
          out_last_n  = (last_q == '0);
        end
      end
      DRAIN: begin
        out_valid_n = 1'b1;
        out_last_n  = out_last;
        if (out_hs) begin
          if (cnt_q == last_q) begin
            state_n      = IDLE;
            out_valid_n  = 1'b0;
            out_last_n   = 1'b0;
            frame_done_n = 1'b1;
          end else begin
            cnt_n      = cnt_q + IDX_W'(1);
            out_last_n = ((cnt_q + IDX_W'(1)) == last_q);
          end
        end
      end
      default: state_n = IDLE;
    endcase

    busy_n = (state_n != IDLE);
  end

endmodule
